regfile_wb_sched: RTL and testbench

//  Write-back scheduler for the 32x32 register file. It shares the single register-file

---
 rtl/regfile_wb_sched.sv | 96 +++++++++
 tb/tb_regfile_wb_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin arbitration of NREQ producers onto the single regfile
// write port (registered, latency 1), plus a busy scoreboard of reserved destinations.
module regfile_wb_sched #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_wa,
  input  logic [NREQ*DW-1:0]   req_wd,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_wa,
  output logic                 rsv_ready,
  output logic [(2**AW)-1:0]   busy,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wa,
  output logic [DW-1:0]        rf_wd
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]       ptr_q;
  logic [(2**AW)-1:0]  busy_q, busy_d;
  logic                rf_we_q;
  logic [AW-1:0]       rf_wa_q;
  logic [DW-1:0]       rf_wd_q;

  logic [NREQ-1:0]     gnt;
  logic [PW-1:0]       gnt_idx;
  logic                gnt_vld;
  logic [PW-1:0]       cand;
  logic [AW-1:0]       sel_wa;
  logic [DW-1:0]       sel_wd;
  logic                clr_vld;

  // Scan starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_vld && !reset && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt[gnt_idx] = gnt_vld;
  end

  assign req_ready = gnt;
  assign sel_wa    = req_wa[int'(gnt_idx)*AW +: AW];
  assign sel_wd    = req_wd[int'(gnt_idx)*DW +: DW];
  assign clr_vld   = gnt_vld && (sel_wa != '0);

  // A reservation may ride on a clear of the same register in this cycle.
  assign rsv_ready = rsv_valid && !reset &&
                     ((rsv_wa == '0) || !busy_q[rsv_wa] || (clr_vld && (sel_wa == rsv_wa)));

  always_comb begin
    busy_d = busy_q;
    if (clr_vld)
      busy_d[sel_wa] = 1'b0;
    if (rsv_ready && (rsv_wa != '0))
      busy_d[rsv_wa] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= PW'(NREQ - 1);
      busy_q  <= '0;
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
    end else begin
      busy_q  <= busy_d;
      rf_we_q <= clr_vld;
      if (gnt_vld) begin
        ptr_q   <= gnt_idx;
        rf_wa_q <= sel_wa;
        rf_wd_q <= sel_wd;
      end
    end
  end

  assign busy  = busy_q;
  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed vector table, reset-in-flight sequence, then
// random traffic checked against a queue/array reference model.
module tb_regfile_wb_sched;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'h2222_2222;
  localparam logic [31:0] W2 = 32'h3333_3333;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_wa;
  logic [NREQ*DW-1:0] req_wd;
  logic               rsv_valid;
  logic [AW-1:0]      rsv_wa;
  logic               rsv_ready;
  logic [31:0]        busy;
  logic               rf_we;
  logic [AW-1:0]      rf_wa;
  logic [DW-1:0]      rf_wd;

  regfile_wb_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wa(req_wa), .req_wd(req_wd),
    .rsv_valid(rsv_valid), .rsv_wa(rsv_wa), .rsv_ready(rsv_ready),
    .busy(busy), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]  vld;
    logic [4:0]  wa0, wa1, wa2;
    logic [31:0] wd1;
    logic        rv;
    logic [4:0]  rwa;
    logic [2:0]  e_rdy;
    logic        e_rsv;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_busy;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  // Reference model state
  int          m_last;
  bit          m_busy [32];
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          pend [NREQ];
  logic [4:0]  pwa  [NREQ];
  logic [31:0] pwd  [NREQ];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    bit rok;
    logic [2:0]  exp_rdy;
    logic [31:0] exp_busy;

    // Directed table, starting from reset (ptr = 2, so req 0 wins first)
    tbl[0]  = '{3'b111, 5'd1, 5'd2, 5'd3, W1, 1'b0, 5'd0, 3'b001, 1'b0, 1'b1, 5'd1, W0, 32'h0};
    tbl[1]  = '{3'b111, 5'd1, 5'd2, 5'd3, W1, 1'b0, 5'd0, 3'b010, 1'b0, 1'b1, 5'd2, W1, 32'h0};
    tbl[2]  = '{3'b111, 5'd1, 5'd2, 5'd3, W1, 1'b0, 5'd0, 3'b100, 1'b0, 1'b1, 5'd3, W2, 32'h0};
    tbl[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, W1, 1'b0, 5'd0, 3'b001, 1'b0, 1'b1, 5'd1, W0, 32'h0};
    tbl[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, W1, 1'b0, 5'd0, 3'b010, 1'b0, 1'b1, 5'd2, W1, 32'h0};
    tbl[5]  = '{3'b111, 5'd1, 5'd2, 5'd3, W1, 1'b0, 5'd0, 3'b100, 1'b0, 1'b1, 5'd3, W2, 32'h0};
    tbl[6]  = '{3'b010, 5'd1, 5'd0, 5'd3, DB, 1'b0, 5'd0, 3'b010, 1'b0, 1'b0, 5'd0, DB, 32'h0};
    for (int i = 7; i < 11; i++)
      tbl[i] = '{3'b000, 5'd1, 5'd2, 5'd3, W1, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 5'd0, DB, 32'h0};
    tbl[11] = '{3'b111, 5'd1, 5'd2, 5'd3, W1, 1'b0, 5'd0, 3'b100, 1'b0, 1'b1, 5'd3, W2, 32'h0};
    tbl[12] = '{3'b000, 5'd1, 5'd2, 5'd3, W1, 1'b1, 5'd5, 3'b000, 1'b1, 1'b0, 5'd3, W2, 32'h20};
    tbl[13] = '{3'b000, 5'd1, 5'd2, 5'd3, W1, 1'b1, 5'd5, 3'b000, 1'b0, 1'b0, 5'd3, W2, 32'h20};
    tbl[14] = '{3'b100, 5'd1, 5'd2, 5'd5, W1, 1'b0, 5'd0, 3'b100, 1'b0, 1'b1, 5'd5, W2, 32'h0};
    tbl[15] = '{3'b000, 5'd1, 5'd2, 5'd3, W1, 1'b1, 5'd7, 3'b000, 1'b1, 1'b0, 5'd5, W2, 32'h80};
    tbl[16] = '{3'b100, 5'd1, 5'd2, 5'd7, W1, 1'b1, 5'd7, 3'b100, 1'b1, 1'b1, 5'd7, W2, 32'h80};

    // Reset state, with requests and a reservation already pending
    reset = 1'b1;
    req_valid = 3'b111;
    req_wa = {5'd3, 5'd2, 5'd1};
    req_wd = {W2, W1, W0};
    rsv_valid = 1'b1;
    rsv_wa = 5'd4;
    #1;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_wa", rf_wa, 0);
    chk("reset_rf_wd", rf_wd, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsv_ready", rsv_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    for (int r = 0; r < NV; r++) begin
      req_valid = tbl[r].vld;
      req_wa    = {tbl[r].wa2, tbl[r].wa1, tbl[r].wa0};
      req_wd    = {W2, tbl[r].wd1, W0};
      rsv_valid = tbl[r].rv;
      rsv_wa    = tbl[r].rwa;
      #2;
      chk($sformatf("vec%0d_req_ready", r), req_ready, tbl[r].e_rdy);
      chk($sformatf("vec%0d_rsv_ready", r), rsv_ready, tbl[r].e_rsv);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rf_we", r), rf_we, tbl[r].e_we);
      chk($sformatf("vec%0d_rf_wa", r), rf_wa, tbl[r].e_wa);
      chk($sformatf("vec%0d_rf_wd", r), rf_wd, tbl[r].e_wd);
      chk($sformatf("vec%0d_busy", r), busy, tbl[r].e_busy);
    end

    // Reserving r0 always succeeds; a busy r7 with no clear stalls
    req_valid = 3'b000; rsv_valid = 1'b1; rsv_wa = 5'd0; #2;
    chk("rsv_r0_ready", rsv_ready, 1);
    @(posedge clk); #1;
    chk("rsv_r0_busy", busy, 32'h80);
    rsv_wa = 5'd7; #2;
    chk("rsv_r7_stall", rsv_ready, 0);
    @(posedge clk); #1;

    // Drive rf_we high, then reset in flight with busy != 0
    req_valid = 3'b001; req_wa = {5'd3, 5'd2, 5'd1}; req_wd = {W2, W1, W0}; rsv_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_rf_we", rf_we, 1);
    chk("pre_reset_busy", busy, 32'h80);
    req_valid = 3'b111; rsv_valid = 1'b1; rsv_wa = 5'd9;
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_rf_we", rf_we, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_req_ready", req_ready, 0);
    chk("midreset_rsv_ready", rsv_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #2;
    chk("post_reset_first_grant", req_ready, 3'b001);

    // Random traffic against the reference model; requests from before reset re-present
    m_last = NREQ - 1;
    foreach (m_busy[r]) m_busy[r] = 1'b0;
    m_we = 1'b0; m_wa = '0; m_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b1;
      pwa[i]  = 5'(i + 1);
    end
    pwd[0] = W0; pwd[1] = W1; pwd[2] = W2;

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pwa[i]  = 5'($urandom_range(0, 7));
          pwd[i]  = $urandom;
        end
        req_valid[i]        = pend[i];
        req_wa[i*AW +: AW]  = pwa[i];
        req_wd[i*DW +: DW]  = pwd[i];
      end
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_wa    = 5'($urandom_range(0, 7));

      g = -1;
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && pend[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      rok = rsv_valid && (rsv_wa == 0 || !m_busy[rsv_wa] ||
                          (g >= 0 && pwa[g] == rsv_wa));

      #2;
      chk($sformatf("rand%0d_req_ready", c), req_ready, exp_rdy);
      chk($sformatf("rand%0d_rsv_ready", c), rsv_ready, rok);

      if (g >= 0) begin
        m_we = (pwa[g] != 0);
        m_wa = pwa[g];
        m_wd = pwd[g];
        if (pwa[g] != 0) m_busy[pwa[g]] = 1'b0;
        m_last = g;
        pend[g] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (rok && rsv_wa != 0) m_busy[rsv_wa] = 1'b1;
      exp_busy = '0;
      for (int r = 1; r < 32; r++) exp_busy[r] = m_busy[r];

      @(posedge clk); #1;
      chk($sformatf("rand%0d_rf_we", c), rf_we, m_we);
      chk($sformatf("rand%0d_rf_wa", c), rf_wa, m_wa);
      chk($sformatf("rand%0d_rf_wd", c), rf_wd, m_wd);
      chk($sformatf("rand%0d_busy", c), busy, exp_busy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
